// File: rtl/matmul_sched.sv
// matmul_sched: computes O = A * B (H x C times C x W, float elements of S bits)
// by time-multiplexing one external multiplier and one external adder.
// Operands are latched on start. The (i, j, k) walk runs k innermost, so
// result elements complete in row-major order. Packing matches the parallel matmul.
module matmul_sched #(
    parameter int S = 32,
    parameter int H = 2,
    parameter int W = 2,
    parameter int C = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [S*H*C-1:0] a,
    input  logic [S*C*W-1:0] b,
    output logic [S*H*W-1:0] o,
    output logic             done,
    output logic             busy,
    output logic             mul_start,
    output logic [S-1:0]     mul_a,
    output logic [S-1:0]     mul_b,
    input  logic [S-1:0]     mul_o,
    input  logic             mul_done,
    output logic             add_start,
    output logic [S-1:0]     add_a,
    output logic [S-1:0]     add_b,
    input  logic [S-1:0]     add_o,
    input  logic             add_done
);

    localparam int IW  = (H > 1) ? $clog2(H) : 1;
    localparam int JW  = (W > 1) ? $clog2(W) : 1;
    localparam int KW  = (C > 1) ? $clog2(C) : 1;
    localparam int AIW = $clog2(S*H*C);
    localparam int BIW = $clog2(S*C*W);
    localparam int OIW = $clog2(S*H*W);

    typedef enum logic [2:0] {
        IDLE, MUL_ISSUE, MUL_WAIT, ADD_ISSUE, ADD_WAIT, STORE
    } state_t;

    state_t           state_q;
    logic [S*H*C-1:0] a_q;
    logic [S*C*W-1:0] b_q;
    logic [S*H*W-1:0] o_q;
    logic [S-1:0]     acc_q, p_q;
    logic [IW-1:0]    i_q;
    logic [JW-1:0]    j_q;
    logic [KW-1:0]    k_q;
    logic             done_q, busy_q;
    logic             mul_start_q, add_start_q;
    logic [S-1:0]     mul_a_q, mul_b_q, add_a_q, add_b_q;

    // Next-index values and the operand pair for the next multiply issue
    logic             last_i_d, last_j_d, last_k_d;
    logic [IW-1:0]    i_nx_d, iss_i_d;
    logic [JW-1:0]    j_nx_d, iss_j_d;
    logic [KW-1:0]    k_inc_d, iss_k_d;
    int               slot_a_d, slot_b_d, slot_o_d;
    logic [S-1:0]     opa_d, opb_d;

    // Compute wrap-around indices and select A(i,k) / B(k,j) for the next issue
    always_comb begin
        last_i_d = (i_q == IW'(H-1));
        last_j_d = (j_q == JW'(W-1));
        last_k_d = (k_q == KW'(C-1));
        k_inc_d  = last_k_d ? '0 : k_q + KW'(1);
        j_nx_d   = last_j_d ? '0 : j_q + JW'(1);
        i_nx_d   = i_q;
        if (last_j_d) begin
            i_nx_d = last_i_d ? '0 : i_q + IW'(1);
        end
        // From STORE the next issue starts a new element; otherwise it is the next k
        iss_i_d  = (state_q == STORE) ? i_nx_d : i_q;
        iss_j_d  = (state_q == STORE) ? j_nx_d : j_q;
        iss_k_d  = (state_q == STORE) ? '0     : k_inc_d;
        slot_a_d = H*C - 1 - (int'(iss_k_d)*H + int'(iss_i_d));
        slot_b_d = C*W - 1 - (int'(iss_j_d)*C + int'(iss_k_d));
        slot_o_d = H*W - 1 - (int'(i_q)*W + int'(j_q));
        opa_d    = a_q[AIW'(S*slot_a_d) +: S];
        opb_d    = b_q[BIW'(S*slot_b_d) +: S];
    end

    // Sequencer FSM with registered handshake, operand and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            o_q         <= '0;
            acc_q       <= '0;
            p_q         <= '0;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            mul_start_q <= 1'b0;
            add_start_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q         <= a;
                        b_q         <= b;
                        i_q         <= '0;
                        j_q         <= '0;
                        k_q         <= '0;
                        done_q      <= 1'b0;
                        busy_q      <= 1'b1;
                        // Element (0,0), k=0 lives in the top slot of each bus
                        mul_start_q <= 1'b1;
                        mul_a_q     <= a[S*(H*C-1) +: S];
                        mul_b_q     <= b[S*(C*W-1) +: S];
                        state_q     <= MUL_ISSUE;
                    end
                end
                MUL_ISSUE: begin
                    mul_start_q <= 1'b0;
                    state_q     <= MUL_WAIT;
                end
                MUL_WAIT: begin
                    if (mul_done) begin
                        p_q <= mul_o;
                        if (k_q == '0) begin
                            // First product seeds the accumulator; no add needed
                            acc_q <= mul_o;
                            if (C == 1) begin
                                state_q <= STORE;
                            end else begin
                                k_q         <= k_inc_d;
                                mul_start_q <= 1'b1;
                                mul_a_q     <= opa_d;
                                mul_b_q     <= opb_d;
                                state_q     <= MUL_ISSUE;
                            end
                        end else begin
                            // mul_o is the value p takes on this edge
                            add_start_q <= 1'b1;
                            add_a_q     <= acc_q;
                            add_b_q     <= mul_o;
                            state_q     <= ADD_ISSUE;
                        end
                    end
                end
                ADD_ISSUE: begin
                    add_start_q <= 1'b0;
                    state_q     <= ADD_WAIT;
                end
                ADD_WAIT: begin
                    if (add_done) begin
                        acc_q <= add_o;
                        if (last_k_d) begin
                            state_q <= STORE;
                        end else begin
                            k_q         <= k_inc_d;
                            mul_start_q <= 1'b1;
                            mul_a_q     <= opa_d;
                            mul_b_q     <= opb_d;
                            state_q     <= MUL_ISSUE;
                        end
                    end
                end
                STORE: begin
                    o_q[OIW'(S*slot_o_d) +: S] <= acc_q;
                    k_q <= '0;
                    i_q <= i_nx_d;
                    j_q <= j_nx_d;
                    if (last_i_d && last_j_d) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        mul_start_q <= 1'b1;
                        mul_a_q     <= opa_d;
                        mul_b_q     <= opb_d;
                        state_q     <= MUL_ISSUE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o         = o_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign mul_start = mul_start_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign add_start = add_start_q;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;

endmodule

// File: tb/tb_matmul_sched.sv
// Directed bench for matmul_sched: a 2x2x2 instance and a 2x2 C=1 instance
// share one behavioural float multiplier/adder with programmable latency.
module tb_matmul_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         start0, start1;
    logic [127:0] a0, b0, o0, o1;
    logic [63:0]  a1, b1;
    logic         done0, busy0, ms0, as0, done1, busy1, ms1, as1;
    logic [31:0]  ma0, mb0, aa0, ab0, ma1, mb1, aa1, ab1;
    logic [31:0]  mul_o, add_o;
    logic         mdone_r, adone_r, inj_mul, mul_done, add_done;
    logic         use1;

    assign mul_done = mdone_r | inj_mul;
    assign add_done = adone_r;

    matmul_sched #(.S(32), .H(2), .W(2), .C(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0), .o(o0),
        .done(done0), .busy(busy0),
        .mul_start(ms0), .mul_a(ma0), .mul_b(mb0), .mul_o(mul_o), .mul_done(mul_done),
        .add_start(as0), .add_a(aa0), .add_b(ab0), .add_o(add_o), .add_done(add_done));

    matmul_sched #(.S(32), .H(2), .W(2), .C(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .o(o1),
        .done(done1), .busy(busy1),
        .mul_start(ms1), .mul_a(ma1), .mul_b(mb1), .mul_o(mul_o), .mul_done(mul_done),
        .add_start(as1), .add_a(aa1), .add_b(ab1), .add_o(add_o), .add_done(add_done));

    // float32 <-> float64 for normal values and zero (all values used here are small integers)
    function automatic logic [63:0] f2d(input logic [31:0] f);
        logic [10:0] e;
        if (f[30:0] == 31'd0) return {f[31], 63'd0};
        e = {3'b000, f[30:23]} + 11'd896;
        return {f[31], e, f[22:0], 29'd0};
    endfunction

    function automatic logic [31:0] d2f(input logic [63:0] d);
        logic [10:0] e;
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] y);
        return d2f($realtobits($bitstoreal(f2d(x)) * $bitstoreal(f2d(y))));
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
        return d2f($realtobits($bitstoreal(f2d(x)) + $bitstoreal(f2d(y))));
    endfunction

    // Shared-unit model: done is high in the cycle lm/la cycles after the start cycle
    logic        mstart, astart;
    logic [31:0] ma, mb, aa, ab, mres, ares;
    int          lm = 1, la = 1, mcnt = 0, acnt = 0;
    assign mstart = use1 ? ms1 : ms0;
    assign astart = use1 ? as1 : as0;
    assign ma = use1 ? ma1 : ma0;
    assign mb = use1 ? mb1 : mb0;
    assign aa = use1 ? aa1 : aa0;
    assign ab = use1 ? ab1 : ab0;

    always @(posedge clk) begin
        mdone_r <= 1'b0;
        adone_r <= 1'b0;
        if (mcnt > 1) mcnt <= mcnt - 1;
        else if (mcnt == 1) begin mcnt <= 0; mdone_r <= 1'b1; mul_o <= mres; end
        if (acnt > 1) acnt <= acnt - 1;
        else if (acnt == 1) begin acnt <= 0; adone_r <= 1'b1; add_o <= ares; end
        if (mstart) begin
            mres <= fmul(ma, mb);
            if (lm == 1) begin mdone_r <= 1'b1; mul_o <= fmul(ma, mb); end
            else mcnt <= lm - 1;
        end
        if (astart) begin
            ares <= fadd(aa, ab);
            if (la == 1) begin adone_r <= 1'b1; add_o <= fadd(aa, ab); end
            else acnt <= la - 1;
        end
    end

    // Pulse bookkeeping across both instances
    int   nmul = 0, nadd = 0, novl = 0, nb2b = 0;
    logic prev_m = 1'b0, prev_a = 1'b0;
    always @(posedge clk) begin
        if (ms0 | ms1) nmul <= nmul + 1;
        if (as0 | as1) nadd <= nadd + 1;
        if ((ms0 | ms1) && (as0 | as1)) novl <= novl + 1;
        if (((ms0 | ms1) && prev_m) || ((as0 | as1) && prev_a)) nb2b <= nb2b + 1;
        prev_m <= ms0 | ms1;
        prev_a <= as0 | as1;
    end

    int npass = 0, ntot = 0;

    localparam logic [127:0] A_P  = {32'h3F800000, 32'h40400000, 32'h40000000, 32'h40800000};
    localparam logic [127:0] A_I  = {32'h3F800000, 32'h00000000, 32'h00000000, 32'h3F800000};
    localparam logic [127:0] B_P  = {32'h40A00000, 32'h40E00000, 32'h40C00000, 32'h41000000};
    localparam logic [127:0] O_P  = {32'h41980000, 32'h41B00000, 32'h422C0000, 32'h42480000};
    localparam logic [127:0] O_I  = {32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    localparam logic [63:0]  A_C1 = {32'h40000000, 32'h40400000};
    localparam logic [63:0]  B_C1 = {32'h40A00000, 32'h40C00000};
    localparam logic [127:0] O_C1 = {32'h41200000, 32'h41400000, 32'h41700000, 32'h41900000};

    // Start a product and count rising edges (the start-sampling edge is edge 1) until done.
    // mode 1 disturbs the run with ignored inputs; stop_at != 0 returns early at that edge.
    task automatic run(input bit which, input int mode, input int stop_at, output int edges,
                       output bit ok, output bit busy_e1, output bit done_e1,
                       output logic [127:0] o_e2);
        @(negedge clk);
        if (which) start1 = 1'b1; else start0 = 1'b1;
        edges = 0; ok = 1'b0; busy_e1 = 1'b0; done_e1 = 1'b0; o_e2 = '0;
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            edges++;
            if (edges == 1) begin
                start0 = 1'b0; start1 = 1'b0;
                busy_e1 = which ? busy1 : busy0;
                done_e1 = which ? done1 : done0;
            end
            if (edges == 2) o_e2 = which ? o1 : o0;
            if (mode == 1) begin
                if (edges == 10) begin start0 = 1'b1; a0 = 128'hDEADBEEF_12345678_0BADF00D_CAFEF00D; end
                if (edges == 11) start0 = 1'b0;
                inj_mul = (edges == 6 || edges == 13);
            end
            if (stop_at != 0 && edges == stop_at) return;
            if (edges > 1 && (which ? done1 : done0)) begin ok = 1'b1; return; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        ntot++; if (o0 !== 128'd0) $display("FAIL reset_o got=%h want=0", o0); else npass++;
        ntot++; if (done0 !== 1'b0) $display("FAIL reset_done got=%b want=0", done0); else npass++;
        ntot++; if (busy0 !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy0); else npass++;
        ntot++; if ({ms0, as0} !== 2'b00) $display("FAIL reset_starts got=%b want=00", {ms0, as0}); else npass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_product();
        int e; bit ok, b1e, d1e; logic [127:0] oe;
        lm = 1; la = 1; a0 = A_P; b0 = B_P;
        run(1'b0, 0, 0, e, ok, b1e, d1e, oe);
        ntot++; if (!ok) $display("FAIL prod_timeout edges=%0d want done", e); else npass++;
        ntot++; if (e != 29) $display("FAIL prod_latency got=%0d want=29", e); else npass++;
        ntot++; if (b1e !== 1'b1) $display("FAIL prod_busy_rise got=%b want=1", b1e); else npass++;
        ntot++; if (o0 !== O_P) $display("FAIL prod_o got=%h want=%h", o0, O_P); else npass++;
        ntot++; if (busy0 !== 1'b0) $display("FAIL prod_busy_end got=%b want=0", busy0); else npass++;
    endtask

    task automatic test_identity();
        int e; bit ok, b1e, d1e; logic [127:0] oe;
        lm = 1; la = 1; a0 = A_I; b0 = B_P;
        run(1'b0, 0, 0, e, ok, b1e, d1e, oe);
        ntot++; if (o0 !== O_I || !ok) $display("FAIL ident_o got=%h want=%h", o0, O_I); else npass++;
        lm = 3; la = 5;
        run(1'b0, 0, 0, e, ok, b1e, d1e, oe);
        ntot++; if (o0 !== O_I || !ok) $display("FAIL ident_slow_o got=%h want=%h", o0, O_I); else npass++;
        ntot++; if (e != 61) $display("FAIL ident_slow_latency got=%0d want=61", e); else npass++;
        lm = 1; la = 1;
    endtask

    task automatic test_c1();
        int e, m0, a0c; bit ok, b1e, d1e; logic [127:0] oe;
        use1 = 1'b1; a1 = A_C1; b1 = B_C1; m0 = nmul; a0c = nadd;
        run(1'b1, 0, 0, e, ok, b1e, d1e, oe);
        ntot++; if (o1 !== O_C1 || !ok) $display("FAIL c1_o got=%h want=%h", o1, O_C1); else npass++;
        ntot++; if (e != 13) $display("FAIL c1_latency got=%0d want=13", e); else npass++;
        ntot++; if (nadd - a0c != 0) $display("FAIL c1_add_pulses got=%0d want=0", nadd - a0c); else npass++;
        ntot++; if (nmul - m0 != 4) $display("FAIL c1_mul_pulses got=%0d want=4", nmul - m0); else npass++;
        use1 = 1'b0;
    endtask

    task automatic test_ignored();
        int e, m0, a0c; bit ok, b1e, d1e; logic [127:0] oe;
        a0 = A_P; b0 = B_P; m0 = nmul; a0c = nadd;
        run(1'b0, 1, 0, e, ok, b1e, d1e, oe);
        inj_mul = 1'b0;
        ntot++; if (o0 !== O_P || !ok) $display("FAIL ign_o got=%h want=%h", o0, O_P); else npass++;
        ntot++; if (nmul - m0 != 8) $display("FAIL ign_mul_pulses got=%0d want=8", nmul - m0); else npass++;
        ntot++; if (nadd - a0c != 4) $display("FAIL ign_add_pulses got=%0d want=4", nadd - a0c); else npass++;
        ntot++; if (e != 29) $display("FAIL ign_latency got=%0d want=29", e); else npass++;
    endtask

    task automatic test_reset_midrun();
        int e; bit ok, b1e, d1e; logic [127:0] oe;
        a0 = A_I; b0 = B_P;
        run(1'b0, 0, 0, e, ok, b1e, d1e, oe);
        a0 = A_P; b0 = B_P;
        run(1'b0, 0, 20, e, ok, b1e, d1e, oe);
        ntot++; if (o0[127:96] !== 32'h41980000) $display("FAIL mid_partial got=%h want=41980000", o0[127:96]); else npass++;
        rst_n = 1'b0;
        #1;
        ntot++; if (o0 !== 128'd0) $display("FAIL mid_rst_o got=%h want=0", o0); else npass++;
        ntot++; if ({done0, busy0} !== 2'b00) $display("FAIL mid_rst_flags got=%b want=00", {done0, busy0}); else npass++;
        @(negedge clk);
        rst_n = 1'b1;
        run(1'b0, 0, 0, e, ok, b1e, d1e, oe);
        ntot++; if (o0 !== O_P || !ok) $display("FAIL mid_rerun_o got=%h want=%h", o0, O_P); else npass++;
        ntot++; if (e != 29) $display("FAIL mid_rerun_latency got=%0d want=29", e); else npass++;
    endtask

    task automatic test_back_to_back();
        int e; bit ok, b1e, d1e; logic [127:0] oe;
        a0 = A_I; b0 = B_P;
        run(1'b0, 0, 0, e, ok, b1e, d1e, oe);
        ntot++; if (o0 !== O_I || !ok) $display("FAIL b2b_first_o got=%h want=%h", o0, O_I); else npass++;
        a0 = A_P;
        run(1'b0, 0, 0, e, ok, b1e, d1e, oe);
        ntot++; if (d1e !== 1'b0) $display("FAIL b2b_done_drop got=%b want=0", d1e); else npass++;
        ntot++; if (b1e !== 1'b1) $display("FAIL b2b_busy_rise got=%b want=1", b1e); else npass++;
        ntot++; if (oe !== O_I) $display("FAIL b2b_o_held got=%h want=%h", oe, O_I); else npass++;
        ntot++; if (o0 !== O_P || !ok) $display("FAIL b2b_second_o got=%h want=%h", o0, O_P); else npass++;
        ntot++; if (done0 !== 1'b1) $display("FAIL b2b_done_end got=%b want=1", done0); else npass++;
    endtask

    task automatic test_pulse_rules();
        ntot++; if (novl != 0) $display("FAIL pulse_overlap got=%0d want=0", novl); else npass++;
        ntot++; if (nb2b != 0) $display("FAIL pulse_back_to_back got=%0d want=0", nb2b); else npass++;
    endtask

    initial begin
        rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; use1 = 1'b0; inj_mul = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        test_reset();
        test_product();
        test_identity();
        test_c1();
        test_ignored();
        test_reset_midrun();
        test_back_to_back();
        test_pulse_rules();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
